// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with ready/valid handshake, flush and optional skid entry.
// Control fields of any empty slot are zeroed so downstream stages never act on a bubble.
module ex_mem_stage_reg #(
  parameter int XLEN  = 64,
  parameter int RD_W  = 5,
  parameter int WB_W  = 2,
  parameter int MEM_W = 3,
  parameter int F3_W  = 3,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [WB_W-1:0]  wb_ctrl_ex,
  input  logic [MEM_W-1:0] mem_ctrl_ex,
  input  logic [XLEN-1:0]  branch_addr_ex,
  input  logic [XLEN-1:0]  alu_result_ex,
  input  logic [XLEN-1:0]  read_data2_ex,
  input  logic             zero_ex,
  input  logic             less_ex,
  input  logic [RD_W-1:0]  rd_ex,
  input  logic [F3_W-1:0]  funct3_ex,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WB_W-1:0]  wb_ctrl_mem,
  output logic [MEM_W-1:0] mem_ctrl_mem,
  output logic [XLEN-1:0]  branch_addr_mem,
  output logic [XLEN-1:0]  alu_result_mem,
  output logic [XLEN-1:0]  read_data2_mem,
  output logic             zero_mem,
  output logic             less_mem,
  output logic [RD_W-1:0]  rd_mem,
  output logic [F3_W-1:0]  funct3_mem,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CTRL_W = WB_W + MEM_W;
  localparam int BW     = CTRL_W + 3 * XLEN + 2 + RD_W + F3_W;

  logic [BW-1:0]    in_bundle;
  logic [BW-1:0]    main_q, main_d;
  logic [BW-1:0]    skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             take;
  logic             drain;

  // Control fields sit in the top bits so a bubble can be zeroed with one slice.
  assign in_bundle = {wb_ctrl_ex, mem_ctrl_ex, branch_addr_ex, alu_result_ex,
                      read_data2_ex, zero_ex, less_ex, rd_ex, funct3_ex};

  assign in_ready = (SKID != 0) ? !skid_valid_q : (!main_valid_q || out_ready);
  assign take     = in_valid && in_ready && !flush;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (drain) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = take;
          if (take) main_d = in_bundle;
        end
      end else if (take) begin
        if (main_valid_q) begin
          skid_d       = in_bundle;
          skid_valid_d = 1'b1;
        end else begin
          main_d       = in_bundle;
          main_valid_d = 1'b1;
        end
      end
    end else begin
      skid_valid_d = 1'b0;
      if (take) begin
        main_d       = in_bundle;
        main_valid_d = 1'b1;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
    end
    // An empty main slot must present zero control; data fields keep their last value.
    if (!main_valid_d) main_d[BW-1 -: CTRL_W] = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign {wb_ctrl_mem, mem_ctrl_mem, branch_addr_mem, alu_result_mem,
          read_data2_mem, zero_mem, less_mem, rd_mem, funct3_mem} = main_q;

endmodule
